// File: rtl/cordic_qr_sched.sv
// Control scheduler for the 4x4 Givens-rotation QR CORDIC datapath: row load,
// fixed vectoring/rotation schedule over one shared engine, then R readout.
module cordic_qr_sched #(
    parameter int ITER = 12,
    parameter int N    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       load_we,
    output logic [1:0] load_row,
    output logic       eng_start,
    output logic       eng_mode,
    output logic [1:0] eng_row_a,
    output logic [1:0] eng_row_b,
    output logic [1:0] eng_col,
    output logic [3:0] eng_iter,
    output logic       eng_last,
    output logic       eng_scale,
    output logic       eng_wb,
    output logic       rd_en,
    output logic [1:0] rd_row,
    output logic [1:0] rd_col,
    output logic       out_valid,
    output logic       busy
);

    localparam logic [3:0] ITER_LAST = 4'(ITER - 1);
    localparam logic [3:0] OUT_LAST  = 4'(N * N - 1);
    localparam logic [1:0] BEAT_LAST = 2'(N - 1);
    localparam logic [1:0] COL_LAST  = 2'(N - 1);
    localparam logic [1:0] ROW_TOP   = 2'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OP,
        S_SCALE,
        S_WB,
        S_OUT
    } state_t;

    state_t     state, state_d;
    logic [1:0] beat_cnt, beat_cnt_d;
    logic [3:0] iter_cnt, iter_cnt_d;
    logic [3:0] out_cnt, out_cnt_d;
    logic       op_mode, op_mode_d;
    logic [1:0] op_row_a, op_row_a_d;
    logic [1:0] op_col, op_col_d;
    logic [1:0] vec_col, vec_col_d;
    logic       accept;
    logic       last_op;

    // Gating with rst_n keeps load_we low while reset is held, even if in_valid toggles.
    assign accept  = in_valid && rst_n && (state == S_IDLE || state == S_LOAD);
    assign last_op = op_mode && (op_col == COL_LAST) && (vec_col == ROW_TOP);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        iter_cnt_d = iter_cnt;
        out_cnt_d  = out_cnt;
        op_mode_d  = op_mode;
        op_row_a_d = op_row_a;
        op_col_d   = op_col;
        vec_col_d  = vec_col;
        load_we    = 1'b0;
        load_row   = 2'd0;
        eng_start  = 1'b0;
        eng_mode   = 1'b0;
        eng_row_a  = 2'd0;
        eng_row_b  = 2'd0;
        eng_col    = 2'd0;
        eng_iter   = 4'd0;
        eng_last   = 1'b0;
        eng_scale  = 1'b0;
        eng_wb     = 1'b0;
        rd_en      = 1'b0;
        rd_row     = 2'd0;
        rd_col     = 2'd0;

        unique case (state)
            S_IDLE, S_LOAD: begin
                load_we  = accept;
                load_row = beat_cnt;
                if (accept) begin
                    beat_cnt_d = beat_cnt + 2'd1;
                    state_d    = (beat_cnt == BEAT_LAST) ? S_OP : S_LOAD;
                end
            end
            S_OP: begin
                eng_start = (iter_cnt == 4'd0);
                eng_last  = (iter_cnt == ITER_LAST);
                eng_iter  = iter_cnt;
                if (iter_cnt == ITER_LAST) begin
                    iter_cnt_d = 4'd0;
                    state_d    = S_SCALE;
                end else begin
                    iter_cnt_d = iter_cnt + 4'd1;
                end
            end
            S_SCALE: begin
                eng_scale = 1'b1;
                state_d   = S_WB;
            end
            S_WB: begin
                eng_wb = 1'b1;
                if (last_op) begin
                    state_d    = S_OUT;
                    op_mode_d  = 1'b0;
                    op_row_a_d = ROW_TOP;
                    op_col_d   = 2'd0;
                    vec_col_d  = 2'd0;
                end else begin
                    state_d = S_OP;
                    // Vectoring at column c is followed by rotations c+1..3; then the
                    // pair moves up, and once the pair top reaches c the column advances.
                    if (!op_mode) begin
                        op_mode_d = 1'b1;
                        op_col_d  = vec_col + 2'd1;
                    end else if (op_col != COL_LAST) begin
                        op_col_d = op_col + 2'd1;
                    end else if (op_row_a != vec_col) begin
                        op_mode_d  = 1'b0;
                        op_row_a_d = op_row_a - 2'd1;
                        op_col_d   = vec_col;
                    end else begin
                        op_mode_d  = 1'b0;
                        op_row_a_d = ROW_TOP;
                        vec_col_d  = vec_col + 2'd1;
                        op_col_d   = vec_col + 2'd1;
                    end
                end
            end
            S_OUT: begin
                rd_en     = 1'b1;
                rd_row    = out_cnt[3:2];
                rd_col    = out_cnt[1:0];
                out_cnt_d = out_cnt + 4'd1;
                if (out_cnt == OUT_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state == S_OP || state == S_SCALE || state == S_WB) begin
            eng_mode  = op_mode;
            eng_row_a = op_row_a;
            eng_row_b = op_row_a + 2'd1;
            eng_col   = op_col;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= 2'd0;
            iter_cnt  <= 4'd0;
            out_cnt   <= 4'd0;
            op_mode   <= 1'b0;
            op_row_a  <= ROW_TOP;
            op_col    <= 2'd0;
            vec_col   <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            beat_cnt  <= beat_cnt_d;
            iter_cnt  <= iter_cnt_d;
            out_cnt   <= out_cnt_d;
            op_mode   <= op_mode_d;
            op_row_a  <= op_row_a_d;
            op_col    <= op_col_d;
            vec_col   <= vec_col_d;
            out_valid <= rd_en;
            // A beat accepted alongside the final out_valid keeps busy high.
            if (accept)                  busy <= 1'b1;
            else if (out_valid && !rd_en) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_qr_sched.sv
// Scoreboard bench for cordic_qr_sched: the stimulus side predicts timed events
// from the schedule rules, and a negedge monitor pops and compares them.
module tb_cordic_qr_sched;

    localparam int ITER  = 12;
    localparam int OPLEN = ITER + 2;
    localparam int INF   = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       load_we;
    logic [1:0] load_row;
    logic       eng_start;
    logic       eng_mode;
    logic [1:0] eng_row_a;
    logic [1:0] eng_row_b;
    logic [1:0] eng_col;
    logic [3:0] eng_iter;
    logic       eng_last;
    logic       eng_scale;
    logic       eng_wb;
    logic       rd_en;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic       out_valid;
    logic       busy;

    cordic_qr_sched #(.ITER(ITER), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .load_we(load_we), .load_row(load_row),
        .eng_start(eng_start), .eng_mode(eng_mode),
        .eng_row_a(eng_row_a), .eng_row_b(eng_row_b), .eng_col(eng_col),
        .eng_iter(eng_iter), .eng_last(eng_last), .eng_scale(eng_scale),
        .eng_wb(eng_wb), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int row; } load_t;
    typedef struct { int start; int mode; int row_a; int col; } op_t;
    typedef struct { int cyc; int addr; } rd_t;

    load_t q_load[$];
    op_t   q_op[$];
    rd_t   q_rd[$];
    int    q_ov[$];

    int n_checks = 0;
    int n_fail   = 0;
    int beats, accept_from, busy_lo, busy_hi, n_loaded, last_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({load_we, load_row, eng_start, eng_mode, eng_row_a, eng_row_b,
                     eng_col, eng_iter, eng_last, eng_scale, eng_wb, rd_en,
                     rd_row, rd_col, out_valid, busy});
    endfunction

    task automatic model_reset();
        q_load.delete();
        q_op.delete();
        q_rd.delete();
        q_ov.delete();
        beats       = 0;
        accept_from = 0;
        busy_lo     = 0;
        busy_hi     = 0;
    endtask

    // Reference schedule: for each column, pairs from the bottom up, each a
    // vectoring op followed by rotations on the remaining columns.
    task automatic push_matrix(input int t);
        int k;
        int r0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            for (int p = 2; p >= c; p--) begin
                q_op.push_back('{t + 1 + k * OPLEN, 0, p, c});
                k++;
                for (int cc = c + 1; cc < 4; cc++) begin
                    q_op.push_back('{t + 1 + k * OPLEN, 1, p, cc});
                    k++;
                end
            end
        end
        r0 = t + 1 + k * OPLEN;
        for (int a = 0; a < 16; a++) begin
            q_rd.push_back('{r0 + a, a});
            q_ov.push_back(r0 + a + 1);
        end
        accept_from = r0 + 16;
        busy_hi     = r0 + 17;
    endtask

    task automatic step(input bit v);
        @(posedge clk);
        #1;
        in_valid = v;
        if (v && rst_n && cyc >= accept_from) begin
            if (beats == 0) begin
                if (cyc + 1 > busy_hi) busy_lo = cyc + 1;
                busy_hi = INF;
            end
            q_load.push_back('{cyc, beats});
            beats++;
            if (beats == 4) begin
                beats = 0;
                n_loaded++;
                last_t = cyc;
                push_matrix(cyc);
            end
        end
    endtask

    load_t le;
    op_t   oe;
    op_t   cur;
    rd_t   re;
    int    ove;
    int    d;
    bit    cur_active = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_active = 1'b0;
            check("reset_outputs_zero", all_outs(), 0);
        end else begin
            if (load_we || (q_load.size() > 0 && q_load[0].cyc <= cyc)) begin
                if (q_load.size() == 0) check("load_unexpected", int'(load_we), 0);
                else begin
                    le = q_load.pop_front();
                    check("load_cycle", cyc, le.cyc);
                    check("load_we", int'(load_we), 1);
                    check("load_row", int'(load_row), le.row);
                end
            end

            if (eng_start || (q_op.size() > 0 && q_op[0].start <= cyc)) begin
                if (q_op.size() == 0) check("start_unexpected", int'(eng_start), 0);
                else begin
                    oe = q_op.pop_front();
                    check("op_start_cycle", cyc, oe.start);
                    check("op_start", int'(eng_start), 1);
                    cur        = oe;
                    cur_active = 1'b1;
                end
            end
            if (cur_active) begin
                d = cyc - cur.start;
                check("eng_mode", int'(eng_mode), cur.mode);
                check("eng_row_a", int'(eng_row_a), cur.row_a);
                check("eng_row_b", int'(eng_row_b), cur.row_a + 1);
                check("eng_col", int'(eng_col), cur.col);
                check("eng_start_pulse", int'(eng_start), int'(d == 0));
                check("eng_last", int'(eng_last), int'(d == ITER - 1));
                check("eng_scale", int'(eng_scale), int'(d == ITER));
                check("eng_wb", int'(eng_wb), int'(d == ITER + 1));
                if (d < ITER) check("eng_iter", int'(eng_iter), d);
                if (d >= ITER + 1) cur_active = 1'b0;
            end else begin
                check("eng_idle_zero", int'({eng_start, eng_mode, eng_row_a, eng_row_b,
                      eng_col, eng_iter, eng_last, eng_scale, eng_wb}), 0);
            end

            if (rd_en || (q_rd.size() > 0 && q_rd[0].cyc <= cyc)) begin
                if (q_rd.size() == 0) check("rd_unexpected", int'(rd_en), 0);
                else begin
                    re = q_rd.pop_front();
                    check("rd_cycle", cyc, re.cyc);
                    check("rd_en", int'(rd_en), 1);
                    check("rd_addr", int'({rd_row, rd_col}), re.addr);
                end
            end

            if (out_valid || (q_ov.size() > 0 && q_ov[0] <= cyc)) begin
                if (q_ov.size() == 0) check("out_valid_unexpected", int'(out_valid), 0);
                else begin
                    ove = q_ov.pop_front();
                    check("out_valid_cycle", cyc, ove);
                    check("out_valid", int'(out_valid), 1);
                end
            end

            check("busy", int'(busy), int'(cyc >= busy_lo && cyc < busy_hi));
        end
    end

    int target;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        n_loaded = 0;
        last_t   = 0;
        model_reset();

        // Reset held with in_valid toggling.
        for (int i = 0; i < 6; i++) step(bit'(i % 2));
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Matrix A: back-to-back beats, quiet input, busy allowed to drop.
        repeat (4) step(1'b1);
        while (cyc + 1 < accept_from + 3) step(1'b0);

        // Matrix B: gapped load, random ignored pulses, next beat on the last out_valid.
        step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b1);
        while (cyc + 1 < accept_from) step(bit'($urandom_range(0, 1)));
        step(1'b1);

        // Matrix C: random gaps, then reset during op 7 iteration 5.
        while (n_loaded < 3) step(bit'($urandom_range(0, 1)));
        target = last_t + 1 + 7 * OPLEN + 5;
        while (cyc + 1 < target) step(bit'($urandom_range(0, 1)));
        step(bit'($urandom_range(0, 1)));
        #1;
        check("pre_reset_iter", int'(eng_iter), 5);
        rst_n = 1'b0;
        #1;
        check("async_reset_zero", all_outs(), 0);
        model_reset();
        for (int i = 0; i < 4; i++) step(bit'($urandom_range(0, 1)));
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Matrix D: fresh load must restart at op 0.
        while (n_loaded < 4) step(bit'($urandom_range(0, 1)));
        while (cyc + 1 < accept_from) step(bit'($urandom_range(0, 1)));
        repeat (3) step(1'b0);

        check("loads_drained", q_load.size(), 0);
        check("ops_drained", q_op.size(), 0);
        check("reads_drained", q_rd.size(), 0);
        check("out_valid_drained", q_ov.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
